// File: rtl/int_sync_crossing_source_stretch_if.sv
// Interrupt lines between the producers, the source-side register stage and software-visible flags.
interface int_sync_crossing_source_stretch_if #(
    parameter int N = 2
);
    logic [N-1:0] auto_in;
    logic [N-1:0] io_mask;
    logic [N-1:0] io_merged_clr;
    logic [N-1:0] auto_out_sync;
    logic [N-1:0] io_merged;

    modport master (
        output auto_in,
        output io_mask,
        output io_merged_clr,
        input  auto_out_sync,
        input  io_merged
    );

    modport slave (
        input  auto_in,
        input  io_mask,
        input  io_merged_clr,
        output auto_out_sync,
        output io_merged
    );
endinterface

// File: rtl/int_sync_crossing_source_stretch.sv
// Registers N interrupt lines before an async sink; edge channels stretch rising edges to STRETCH cycles.
// Latency 1 cycle from input to output; no backpressure, lines are free-running.
module int_sync_crossing_source_stretch #(
    parameter int             N         = 2,
    parameter logic [N-1:0]   EDGE_MASK = '0,
    parameter int             STRETCH   = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    int_sync_crossing_source_stretch_if.slave   bus
);
    localparam int            CW       = $clog2(STRETCH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic out_r;
        logic merged_r;

        assign bus.auto_out_sync[i] = out_r;
        assign bus.io_merged[i]     = merged_r;

        if (EDGE_MASK[i]) begin : g_edge
            logic          in_q;
            logic [CW-1:0] cnt;
            logic          rise;
            logic          merged_set;

            assign rise       = bus.auto_in[i] & ~in_q;
            // An edge landing inside a live stretch window is folded into it; record that.
            assign merged_set = ~bus.io_mask[i] & rise & (cnt != '0);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    in_q     <= 1'b0;
                    cnt      <= '0;
                    out_r    <= 1'b0;
                    merged_r <= 1'b0;
                end else begin
                    in_q     <= bus.auto_in[i];
                    merged_r <= merged_set | (merged_r & ~bus.io_merged_clr[i]);
                    if (bus.io_mask[i]) begin
                        cnt   <= '0;
                        out_r <= 1'b0;
                    end else if (rise) begin
                        cnt   <= CNT_LOAD;
                        out_r <= 1'b1;
                    end else if (cnt != '0) begin
                        cnt   <= cnt - CNT_ONE;
                        out_r <= (cnt != CNT_ONE);
                    end else begin
                        out_r <= 1'b0;
                    end
                end
            end
        end else begin : g_level
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_r    <= 1'b0;
                    merged_r <= 1'b0;
                end else begin
                    out_r    <= bus.auto_in[i] & ~bus.io_mask[i];
                    merged_r <= merged_r & ~bus.io_merged_clr[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_int_sync_crossing_source_stretch.sv
// Directed-vector scoreboard bench: one 2-channel STRETCH=4 instance and one 1-channel STRETCH=1 instance.
module tb_int_sync_crossing_source_stretch;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    int_sync_crossing_source_stretch_if #(.N(2)) bus_a ();
    int_sync_crossing_source_stretch_if #(.N(1)) bus_b ();

    int_sync_crossing_source_stretch #(.N(2), .EDGE_MASK(2'b10), .STRETCH(4)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    int_sync_crossing_source_stretch #(.N(1), .EDGE_MASK(1'b1), .STRETCH(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct packed {
        logic       rst;
        logic [1:0] in_a;
        logic [1:0] mask_a;
        logic [1:0] clr_a;
        logic       in_b;
        logic [1:0] out_a;
        logic [1:0] mrg_a;
        logic       out_b;
        logic       mrg_b;
    } vec_t;

    typedef struct packed {
        int         idx;
        logic [5:0] resp;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic [1:0] in_a, input logic [1:0] mask_a,
                       input logic [1:0] clr_a, input logic in_b, input logic [1:0] out_a,
                       input logic [1:0] mrg_a, input logic out_b, input logic mrg_b);
        vec_t v;
        v = '{rst, in_a, mask_a, clr_a, in_b, out_a, mrg_a, out_b, mrg_b};
        vecs.push_back(v);
    endtask

    // Monitor: every cycle the DUTs present a response; compare it against the oldest expectation.
    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {bus_a.auto_out_sync, bus_a.io_merged, bus_b.auto_out_sync, bus_b.io_merged};
                n_vec++;
                if (got !== e.resp) begin
                    n_bad++;
                    $display("FAIL vec%0d {out_a,merged_a,out_b,merged_b}: got %b expected %b",
                             e.idx, got, e.resp);
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus_a.auto_in       = '0;
        bus_a.io_mask       = '0;
        bus_a.io_merged_clr = '0;
        bus_b.auto_in       = '0;
        bus_b.io_mask       = '0;
        bus_b.io_merged_clr = '0;

        //   rst in   mask clr  inb  out  mrg  ob mb
        add(1, 2'b11, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 0  reset held, inputs high
        add(1, 2'b11, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 1
        add(0, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 1, 0); // 2  release: rise on edge chans
        add(0, 2'b11, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0, 0); // 3
        add(0, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 1, 0); // 4
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 5
        add(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 1, 0); // 6  stretch of 4 ends
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 7
        add(0, 2'b11, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0, 0); // 8  1-cycle pulses on both
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 9
        add(0, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b00, 1, 0); // 10 B held high 2 cycles
        add(0, 2'b00, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 0); // 11
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 12
        add(0, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 13 first pulse
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 14
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 15
        add(0, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 16 retrigger -> merged
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 17
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 18
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 19
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 20 7 cycles high total
        add(0, 2'b00, 2'b00, 2'b10, 0, 2'b00, 2'b00, 0, 0); // 21 clear merged
        add(0, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 22 rise from idle, no merge
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 23
        add(0, 2'b10, 2'b00, 2'b10, 0, 2'b10, 2'b10, 0, 0); // 24 clear vs set: set wins
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 25
        add(0, 2'b00, 2'b10, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 26 mask mid-stretch
        add(0, 2'b10, 2'b10, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 27 edge while masked
        add(0, 2'b10, 2'b00, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 28 unmask, input held high
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 29
        add(0, 2'b01, 2'b01, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 30 level channel masked
        add(0, 2'b01, 2'b00, 2'b00, 0, 2'b01, 2'b10, 0, 0); // 31
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 32
        add(0, 2'b10, 2'b00, 2'b10, 0, 2'b10, 2'b00, 0, 0); // 33 rise from idle, clear
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 34
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 35
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0); // 36 cnt == 1
        add(0, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 37 rise at cnt == 1
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 38
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 39
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 40
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b10, 0, 0); // 41
        add(0, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0); // 42 new stretch
        add(1, 2'b10, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 43 reset mid-stretch
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 44 no pulse after release
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0); // 45

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clock);
            reset               = vecs[k].rst;
            bus_a.auto_in       = vecs[k].in_a;
            bus_a.io_mask       = vecs[k].mask_a;
            bus_a.io_merged_clr = vecs[k].clr_a;
            bus_b.auto_in       = vecs[k].in_b;
            e.idx  = k;
            e.resp = {vecs[k].out_a, vecs[k].mrg_a, vecs[k].out_b, vecs[k].mrg_b};
            exp_q.push_back(e);
        end

        for (int w = 0; w < 8 && exp_q.size() != 0; w++) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
